// File: rtl/cache_arbiter.sv
// cache_arbiter: shares one physical-memory port between I$ and D$.
// Round-robin on conflict, requests latched onto registered mem_* port.
module cache_arbiter #(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_pmem_read,
  input  logic [ADDR_W-1:0] i_pmem_address,
  output logic              i_pmem_resp,
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [ADDR_W-1:0] d_pmem_address,
  input  logic [LINE_W-1:0] d_pmem_wdata,
  output logic              d_pmem_resp,
  output logic [LINE_W-1:0] pmem_rdata_out,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp
);

  typedef enum logic [1:0] {
    IDLE,
    SERVE_I,
    SERVE_D,
    RELEASE
  } state_t;

  state_t state;
  logic   last_d;
  logic   i_req;
  logic   d_req;
  logic   pick_i;
  logic   pick_d;

  // Grant choice: sole requester wins, else whoever was not served last
  always_comb begin
    i_req  = i_pmem_read;
    d_req  = d_pmem_read | d_pmem_write;
    pick_d = d_req & (~i_req | ~last_d);
    pick_i = i_req & (~d_req | last_d);
  end

  // Completion passthrough; held off while reset is asserted
  always_comb begin
    i_pmem_resp = ~rst & mem_resp & (state == SERVE_I);
    d_pmem_resp = ~rst & mem_resp & (state == SERVE_D);
  end

  assign pmem_rdata_out = mem_rdata;

  // Arbitration FSM with registered shared-port outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      last_d      <= 1'b0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_address <= '0;
      mem_wdata   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          unique case (1'b1)
            pick_d: begin
              state       <= SERVE_D;
              last_d      <= 1'b1;
              mem_address <= d_pmem_address;
              mem_write   <= d_pmem_write;
              mem_read    <= ~d_pmem_write;
              if (d_pmem_write)
                mem_wdata <= d_pmem_wdata;
            end
            pick_i: begin
              state       <= SERVE_I;
              last_d      <= 1'b0;
              mem_address <= i_pmem_address;
              mem_read    <= 1'b1;
              mem_write   <= 1'b0;
            end
            default: ;
          endcase
        end
        SERVE_I,
        SERVE_D: begin
          if (mem_resp) begin
            state     <= RELEASE;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
          end
        end
        RELEASE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/cache_arbiter.md
# cache_arbiter

Shares one physical-memory port between the instruction cache and the data cache. Each cache's miss/writeback controller drives its own request pins as if it owned physical memory. The arbiter grants one requester at a time and latches that request onto the shared port. It then returns the response and line data to the granted cache only. It sits between both cache controllers and the physical memory (or L2) interface.

## Interface
- ADDR_W, 16, byte address width
- LINE_W, 128, cache line width in bits
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- i_pmem_read  in  1  I-cache line read request, held until i_pmem_resp
- i_pmem_address  in  ADDR_W  I-cache request address
- i_pmem_resp  out  1  one-cycle completion to I-cache
- d_pmem_read  in  1  D-cache line read request, held until d_pmem_resp
- d_pmem_write  in  1  D-cache line writeback request, held until d_pmem_resp
- d_pmem_address  in  ADDR_W  D-cache request address
- d_pmem_wdata  in  LINE_W  D-cache writeback line
- d_pmem_resp  out  1  one-cycle completion to D-cache
- pmem_rdata_out  out  LINE_W  mem_rdata broadcast to both caches; qualified only by the per-cache resp
- mem_read  out  1  shared-port read, registered
- mem_write  out  1  shared-port write, registered
- mem_address  out  ADDR_W  registered request address
- mem_wdata  out  LINE_W  registered write line
- mem_rdata  in  LINE_W  read line from memory, valid with mem_resp
- mem_resp  in  1  memory completion, one or more cycles after mem_read/mem_write

## Operation
- States: IDLE, SERVE_I, SERVE_D, RELEASE.
- IDLE:
  - i_req = i_pmem_read; d_req = d_pmem_read | d_pmem_write.
  - Only i_req: go to SERVE_I. Only d_req: go to SERVE_D.
  - Both: grant the requester not recorded in last_grant.
  - On grant, latch address, op and wdata into mem_* registers, and set last_grant to the granted requester.
  - If d_pmem_read and d_pmem_write are both high, write wins. mem_wdata is latched only for writes.
- SERVE_I / SERVE_D:
  - mem_read or mem_write stay high and all mem_* registers stay frozen until mem_resp.
  - Requester pins are ignored while serving.
- Response:
  - In the cycle mem_resp=1, the granted cache's resp=1 combinationally. The other cache's resp stays 0.
  - On the same edge, mem_read/mem_write clear and the FSM goes to RELEASE.
- RELEASE: one cycle with no memory request, then IDLE. This lets the served controller change state before requests are sampled again.
- mem_resp in IDLE or RELEASE is ignored: no resp to either cache and no state change.
- last_grant resets to "I". The D-cache therefore wins the first simultaneous conflict, and grants alternate afterwards. A steady requester cannot starve the other.

## Timing
- Reset, synchronous:
  - state=IDLE, last_grant=I.
  - mem_read=0, mem_write=0, mem_address=0, mem_wdata=0.
  - i_pmem_resp=0, d_pmem_resp=0.
- Reset mid-transaction: the memory request drops on the next edge. No resp is issued, and the outstanding memory response is discarded.
- Grant latency: request sampled high in IDLE at cycle N gives mem_read/mem_write high in cycle N+1.
- Completion:
  - If mem_resp is high in cycle M, the cache resp is high in cycle M (zero-cycle passthrough).
  - Cycle M+1 is RELEASE. Cycle M+2 is IDLE, where the next request can be sampled.
  - The next grant's mem request is therefore visible at M+3 at the earliest.
- A request that drops before being granted is never issued.
- pmem_rdata_out = mem_rdata at all times.

## Test plan
- I-only read, address 0x1230; memory responds after 3 cycles with line 0xA5..A5.
  - Required: mem_read high at cycle 1, mem_address=0x1230.
  - Required: i_pmem_resp pulses with mem_resp, and the I-cache sees 0xA5..A5.
  - Required: d_pmem_resp stays 0 throughout.
- D writeback to 0x4440 with wdata 0x0123..EF, followed directly by a D read of 0x8880.
  - Required: mem_write with the latched wdata, then RELEASE, then mem_read at 0x8880.
  - Required: two d_pmem_resp pulses.
- I and D requests asserted together from reset.
  - Required: D is served first.
  - Required: while I keeps requesting, the next conflict grants I, then D, strictly alternating.
- Change d_pmem_address and d_pmem_wdata during SERVE_D.
  - Required: mem_address and mem_wdata hold the values latched at grant until mem_resp.
- Stray mem_resp in IDLE.
  - Required: no resp to either cache and the state stays IDLE.
- Assert rst during SERVE_I with mem_resp pending.
  - Required: all outputs are 0 the next cycle and i_pmem_resp is never asserted.
  - Required: a fresh D request afterwards is granted normally.
